bus_wait_state_controller: RTL and testbench

Sequences ready/wait states for every system-bus cycle after the bus arbiter has committed the command strobes. It classifies each cycle (CPU I/O, CPU memory, interrupt acknowledge, DMA), inserts a programmable number of wait states, and honours the expansion-slot io_channel_ready line with a timeout. It drives processor_ready toward the clock generator and dma_ready toward the DMA controller's ready input.

---
 rtl/bus_wait_state_controller_if.sv | 63 ++++++
 rtl/bus_wait_state_controller.sv | 199 +++++++++++++++++++
 tb/tb_bus_wait_state_controller.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_wait_state_controller_if.sv
// ---------------------------------------------------------------------------
// bus_wait_state_controller_if
//
// Purpose: groups the system-bus command strobes, the expansion-slot ready
// line and the ready/status outputs of the wait-state controller.
//
// Signals:
//   address_enable_n         0 = CPU owns the bus, 1 = DMA owns the bus
//   io_read_n, io_write_n    resolved I/O strobes, active low
//   memory_read_n,
//   memory_write_n           resolved memory strobes, active low
//   interrupt_acknowledge_n  INTA strobe, active low
//   io_channel_ready         asynchronous slot ready, 0 = extend the cycle
//   processor_ready          1 = CPU cycle may complete
//   dma_ready                1 = DMA cycle may complete
//   timeout_error            one-clock pulse on a force-completed cycle
//   bus_cycle_active         1 while a bus cycle is being sequenced
//
// Modports:
//   master  bus side: drives strobes and slot ready, observes readies
//   slave   controller side: observes strobes, drives readies
// ---------------------------------------------------------------------------
interface bus_wait_state_controller_if;
    logic address_enable_n;
    logic io_read_n;
    logic io_write_n;
    logic memory_read_n;
    logic memory_write_n;
    logic interrupt_acknowledge_n;
    logic io_channel_ready;
    logic processor_ready;
    logic dma_ready;
    logic timeout_error;
    logic bus_cycle_active;

    modport master (
        output address_enable_n,
        output io_read_n,
        output io_write_n,
        output memory_read_n,
        output memory_write_n,
        output interrupt_acknowledge_n,
        output io_channel_ready,
        input  processor_ready,
        input  dma_ready,
        input  timeout_error,
        input  bus_cycle_active
    );

    modport slave (
        input  address_enable_n,
        input  io_read_n,
        input  io_write_n,
        input  memory_read_n,
        input  memory_write_n,
        input  interrupt_acknowledge_n,
        input  io_channel_ready,
        output processor_ready,
        output dma_ready,
        output timeout_error,
        output bus_cycle_active
    );
endinterface

// File: rtl/bus_wait_state_controller.sv
// ---------------------------------------------------------------------------
// bus_wait_state_controller
//
// Purpose: sequences ready/wait states for every system-bus cycle once the
// arbiter has committed the command strobes. Each cycle is classified as
// CPU I/O (including INTA), CPU memory or DMA, gets its programmed number of
// wait clocks, and is then extended while the synchronised slot ready line
// is low, up to an optional timeout.
//
// Ports:
//   clock  system clock, all state updates on posedge
//   reset  asynchronous, active-high
//   bus    slave modport of bus_wait_state_controller_if (strobes in,
//          processor_ready / dma_ready / timeout_error / bus_cycle_active out)
//
// Parameters:
//   IO_WAIT_STATES   wait clocks on CPU I/O and INTA cycles (0-15)
//   MEM_WAIT_STATES  wait clocks on CPU memory cycles (0-15)
//   DMA_WAIT_STATES  wait clocks on DMA cycles (0-15)
//   TIMEOUT_CYCLES   max clocks spent waiting on the slot ready line,
//                    0 disables the timeout (1-1023 otherwise)
// ---------------------------------------------------------------------------
module bus_wait_state_controller #(
    parameter int unsigned IO_WAIT_STATES  = 1,
    parameter int unsigned MEM_WAIT_STATES = 0,
    parameter int unsigned DMA_WAIT_STATES = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    bus_wait_state_controller_if.slave    bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_EXT   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] IO_WAITS   = 4'(IO_WAIT_STATES);
    localparam logic [3:0] MEM_WAITS  = 4'(MEM_WAIT_STATES);
    localparam logic [3:0] DMA_WAITS  = 4'(DMA_WAIT_STATES);
    localparam bit         TMO_ENABLE = (TIMEOUT_CYCLES != 0);
    // Value the timeout counter holds on the last permitted EXT clock.
    localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_state;
    logic       r_is_dma;
    logic [3:0] r_wait_cnt;
    logic [9:0] r_tmo_cnt;
    logic       r_processor_ready;
    logic       r_dma_ready;
    logic       r_timeout_error;
    logic       r_bus_active;

    logic       w_rdy_s;
    logic       w_any_cmd;
    logic       w_is_dma_cmd;
    logic       w_is_io_cmd;
    logic [3:0] w_load_waits;
    logic [1:0] w_state_next;
    logic       w_is_dma_next;
    logic [3:0] w_wait_next;
    logic [9:0] w_tmo_next;
    logic       w_tgt_ready_next;
    logic       w_timeout_next;

    // Two-flop synchroniser for the asynchronous slot ready line; only the
    // second stage is ever looked at.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let r_sync2 take the old r_sync1,
            // giving a real two-stage chain; blocking here would collapse it.
            r_sync1 <= bus.io_channel_ready;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rdy_s   = r_sync2;
    assign w_any_cmd = ~(bus.io_read_n & bus.io_write_n & bus.memory_read_n &
                         bus.memory_write_n & bus.interrupt_acknowledge_n);

    // Classification: DMA ownership wins, then I/O/INTA beats memory when
    // the strobes fall together.
    assign w_is_dma_cmd = bus.address_enable_n;
    assign w_is_io_cmd  = ~(bus.io_read_n & bus.io_write_n &
                            bus.interrupt_acknowledge_n);
    assign w_load_waits = w_is_dma_cmd ? DMA_WAITS :
                          w_is_io_cmd  ? IO_WAITS  : MEM_WAITS;

    // w_tgt_ready_next is the next value of whichever ready the latched
    // cycle type targets; the other ready is held at 1.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        w_state_next     = r_state;
        w_is_dma_next    = r_is_dma;
        w_wait_next      = r_wait_cnt;
        w_tmo_next       = r_tmo_cnt;
        w_tgt_ready_next = 1'b1;
        w_timeout_next   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_wait_next = '0;
                w_tmo_next  = '0;
                if (w_any_cmd) begin
                    w_is_dma_next = w_is_dma_cmd;
                    if (w_load_waits != 4'd0) begin
                        w_state_next     = ST_COUNT;
                        w_wait_next      = w_load_waits - 4'd1;
                        w_tgt_ready_next = 1'b0;
                    end else begin
                        w_state_next = ST_EXT;
                    end
                end
            end

            ST_COUNT: begin
                if (!w_any_cmd) begin
                    w_state_next = ST_IDLE;
                end else if (r_wait_cnt != 4'd0) begin
                    w_wait_next      = r_wait_cnt - 4'd1;
                    w_tgt_ready_next = 1'b0;
                end else if (w_rdy_s) begin
                    // Last wait clock with the slot already ready: release
                    // now so the ready is low for exactly the programmed count.
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next     = ST_EXT;
                    w_tgt_ready_next = 1'b0;
                end
            end

            ST_EXT: begin
                if (!w_any_cmd) begin
                    w_state_next = ST_IDLE;
                end else if (w_rdy_s) begin
                    w_state_next = ST_DONE;
                end else if (TMO_ENABLE && (r_tmo_cnt == TMO_LAST)) begin
                    w_state_next   = ST_DONE;
                    w_timeout_next = 1'b1;
                end else begin
                    // Saturate so a disabled timeout never wraps.
                    if (r_tmo_cnt != '1) begin
                        w_tmo_next = r_tmo_cnt + 10'd1;
                    end
                    w_tgt_ready_next = 1'b0;
                end
            end

            ST_DONE: begin
                // Hold here until the strobes are seen deasserted so a
                // lingering strobe cannot start a second cycle.
                if (!w_any_cmd) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_is_dma          <= 1'b0;
            r_wait_cnt        <= '0;
            r_tmo_cnt         <= '0;
            r_processor_ready <= 1'b1;
            r_dma_ready       <= 1'b1;
            r_timeout_error   <= 1'b0;
            r_bus_active      <= 1'b0;
        end else begin
            r_state           <= w_state_next;
            r_is_dma          <= w_is_dma_next;
            r_wait_cnt        <= w_wait_next;
            r_tmo_cnt         <= w_tmo_next;
            r_processor_ready <= w_is_dma_next ? 1'b1 : w_tgt_ready_next;
            r_dma_ready       <= w_is_dma_next ? w_tgt_ready_next : 1'b1;
            r_timeout_error   <= w_timeout_next;
            // Registered copy of the current state, so it trails the state
            // register by one clock.
            r_bus_active      <= (r_state != ST_IDLE);
        end
    end

    assign bus.processor_ready  = r_processor_ready;
    assign bus.dma_ready        = r_dma_ready;
    assign bus.timeout_error    = r_timeout_error;
    assign bus.bus_cycle_active = r_bus_active;

endmodule

// File: tb/tb_bus_wait_state_controller.sv
// ---------------------------------------------------------------------------
// tb_bus_wait_state_controller
//
// Purpose: self-checking bench for bus_wait_state_controller. Two instances
// are used: dut_a with default parameters and dut_b with IO_WAIT_STATES=5,
// DMA_WAIT_STATES=3. Expected outputs are packed as {processor_ready,
// dma_ready, timeout_error, bus_cycle_active}, pushed to a scoreboard queue
// when the stimulus is driven and popped after the next clock edge.
// ---------------------------------------------------------------------------
module tb_bus_wait_state_controller;

    typedef struct {
        string      name;
        bit         sel;       // 0 = dut_a, 1 = dut_b
        bit         aen_n;
        logic [4:0] strobes;   // {ior_n, iow_n, mr_n, mw_n, inta_n}
        bit         chan;
        logic [3:0] exp;       // {pr, dr, te, act}
    } vec_t;

    typedef struct {
        string      name;
        bit         sel;
        logic [3:0] exp;
    } sb_t;

    localparam logic [4:0] S_IDLE   = 5'b11111;
    localparam logic [4:0] S_IOR    = 5'b01111;
    localparam logic [4:0] S_IOW    = 5'b10111;
    localparam logic [4:0] S_MR     = 5'b11011;
    localparam logic [4:0] S_MW     = 5'b11101;
    localparam logic [4:0] S_INTA   = 5'b11110;
    localparam logic [4:0] S_IOW_MR = 5'b10011;

    localparam logic [3:0] O_IDLE    = 4'b1100;
    localparam logic [3:0] O_ACT     = 4'b1101;
    localparam logic [3:0] O_PR0     = 4'b0100;
    localparam logic [3:0] O_PR0_ACT = 4'b0101;
    localparam logic [3:0] O_DR0     = 4'b1000;
    localparam logic [3:0] O_DR0_ACT = 4'b1001;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    sb_t  sb[$];
    vec_t vecs[$];

    always #5 clock = ~clock;

    bus_wait_state_controller_if bus_a ();
    bus_wait_state_controller_if bus_b ();

    bus_wait_state_controller #(
        .IO_WAIT_STATES (1),
        .MEM_WAIT_STATES(0),
        .DMA_WAIT_STATES(1),
        .TIMEOUT_CYCLES (64)
    ) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (bus_a)
    );

    bus_wait_state_controller #(
        .IO_WAIT_STATES (5),
        .MEM_WAIT_STATES(0),
        .DMA_WAIT_STATES(3),
        .TIMEOUT_CYCLES (64)
    ) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (bus_b)
    );

    function automatic vec_t mk(input string name, input bit sel, input bit aen_n,
                                input logic [4:0] strobes, input bit chan,
                                input logic [3:0] exp);
        vec_t v;
        v.name = name; v.sel = sel; v.aen_n = aen_n;
        v.strobes = strobes; v.chan = chan; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] actual,
                         input logic [3:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: pr/dr/te/act got %b expected %b at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic drive_bus(input bit sel, input bit aen_n,
                             input logic [4:0] strobes, input bit chan);
        // The unselected instance always sees an idle bus.
        bus_a.address_enable_n        = sel ? 1'b0 : aen_n;
        bus_a.io_read_n               = sel ? 1'b1 : strobes[4];
        bus_a.io_write_n              = sel ? 1'b1 : strobes[3];
        bus_a.memory_read_n           = sel ? 1'b1 : strobes[2];
        bus_a.memory_write_n          = sel ? 1'b1 : strobes[1];
        bus_a.interrupt_acknowledge_n = sel ? 1'b1 : strobes[0];
        bus_a.io_channel_ready        = sel ? 1'b1 : chan;
        bus_b.address_enable_n        = sel ? aen_n : 1'b0;
        bus_b.io_read_n               = sel ? strobes[4] : 1'b1;
        bus_b.io_write_n              = sel ? strobes[3] : 1'b1;
        bus_b.memory_read_n           = sel ? strobes[2] : 1'b1;
        bus_b.memory_write_n          = sel ? strobes[1] : 1'b1;
        bus_b.interrupt_acknowledge_n = sel ? strobes[0] : 1'b1;
        bus_b.io_channel_ready        = sel ? chan : 1'b1;
    endtask

    task automatic push_exp(input string name, input bit sel, input logic [3:0] exp);
        sb_t e;
        e.name = name; e.sel = sel; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic sample();
        sb_t        e;
        logic [3:0] actual;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: sample with no expected entry");
            return;
        end
        e = sb.pop_front();
        actual = e.sel ? {bus_b.processor_ready, bus_b.dma_ready,
                          bus_b.timeout_error, bus_b.bus_cycle_active}
                       : {bus_a.processor_ready, bus_a.dma_ready,
                          bus_a.timeout_error, bus_a.bus_cycle_active};
        check(e.name, actual, e.exp);
    endtask

    // Drive one clock of stimulus and check the outputs just after the edge.
    task automatic apply(input vec_t v);
        drive_bus(v.sel, v.aen_n, v.strobes, v.chan);
        push_exp(v.name, v.sel, v.exp);
        @(posedge clock);
        #1;
        sample();
    endtask

    task automatic step(input string name, input bit sel, input bit aen_n,
                        input logic [4:0] strobes, input bit chan,
                        input logic [3:0] exp);
        apply(mk(name, sel, aen_n, strobes, chan, exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // CPU I/O read, one wait state, slot ready.
        vecs.push_back(mk("ior_k",      0, 0, S_IOR,  1, O_PR0));
        vecs.push_back(mk("ior_k1",     0, 0, S_IOR,  1, O_ACT));
        vecs.push_back(mk("ior_done",   0, 0, S_IOR,  1, O_ACT));
        vecs.push_back(mk("ior_rel",    0, 0, S_IDLE, 1, O_ACT));
        vecs.push_back(mk("ior_idle",   0, 0, S_IDLE, 1, O_IDLE));
        // CPU memory read, zero wait states: ready never drops.
        vecs.push_back(mk("mr_k",       0, 0, S_MR,   1, O_IDLE));
        vecs.push_back(mk("mr_k1",      0, 0, S_MR,   1, O_ACT));
        vecs.push_back(mk("mr_done",    0, 0, S_MR,   1, O_ACT));
        vecs.push_back(mk("mr_rel",     0, 0, S_IDLE, 1, O_ACT));
        vecs.push_back(mk("mr_idle",    0, 0, S_IDLE, 1, O_IDLE));
        // INTA counts as an I/O cycle.
        vecs.push_back(mk("inta_k",     0, 0, S_INTA, 1, O_PR0));
        vecs.push_back(mk("inta_k1",    0, 0, S_INTA, 1, O_ACT));
        vecs.push_back(mk("inta_rel",   0, 0, S_IDLE, 1, O_ACT));
        vecs.push_back(mk("inta_idle",  0, 0, S_IDLE, 1, O_IDLE));
        // I/O and memory strobes together: I/O timing wins.
        vecs.push_back(mk("iomr_k",     0, 0, S_IOW_MR, 1, O_PR0));
        vecs.push_back(mk("iomr_k1",    0, 0, S_IOW_MR, 1, O_ACT));
        vecs.push_back(mk("iomr_rel",   0, 0, S_IDLE, 1, O_ACT));
        vecs.push_back(mk("iomr_idle",  0, 0, S_IDLE, 1, O_IDLE));
        // DMA write on dut_a, one wait state on dma_ready.
        vecs.push_back(mk("dmaa_k",     0, 1, S_MW,   1, O_DR0));
        vecs.push_back(mk("dmaa_k1",    0, 1, S_MW,   1, O_ACT));
        vecs.push_back(mk("dmaa_rel",   0, 1, S_IDLE, 1, O_ACT));
        vecs.push_back(mk("dmaa_idle",  0, 0, S_IDLE, 1, O_IDLE));
        // DMA write on dut_b, three wait states; address_enable_n drops
        // mid-cycle and must be ignored.
        vecs.push_back(mk("dmab_k",     1, 1, S_MW,   1, O_DR0));
        vecs.push_back(mk("dmab_k1",    1, 0, S_MW,   1, O_DR0_ACT));
        vecs.push_back(mk("dmab_k2",    1, 0, S_MW,   1, O_DR0_ACT));
        vecs.push_back(mk("dmab_k3",    1, 0, S_MW,   1, O_ACT));
        vecs.push_back(mk("dmab_rel",   1, 1, S_IDLE, 1, O_ACT));
        vecs.push_back(mk("dmab_idle",  1, 0, S_IDLE, 1, O_IDLE));
        // Abort in COUNT on dut_b (five I/O wait states).
        vecs.push_back(mk("abort_k",    1, 0, S_IOR,  1, O_PR0));
        vecs.push_back(mk("abort_k1",   1, 0, S_IOR,  1, O_PR0_ACT));
        vecs.push_back(mk("abort_rel",  1, 0, S_IDLE, 1, O_ACT));
        vecs.push_back(mk("abort_idle", 1, 0, S_IDLE, 1, O_IDLE));
        vecs.push_back(mk("abort_idl2", 1, 0, S_IDLE, 1, O_IDLE));

        // Reset values, checked on both instances while reset is held.
        reset = 1'b1;
        drive_bus(1'b0, 1'b0, S_IDLE, 1'b1);
        #12;
        push_exp("reset_a", 0, O_IDLE);
        sample();
        push_exp("reset_b", 1, O_IDLE);
        sample();
        @(negedge clock);
        reset = 1'b0;

        step("post_reset", 0, 0, S_IDLE, 1, O_IDLE);

        foreach (vecs[i]) apply(vecs[i]);

        // I/O write with the slot held low until 10 clocks after the strobe
        // edge: ready is low for 1 wait + 10 + 2 synchroniser clocks.
        for (int i = 0; i < 3; i++) step("ext_pre", 0, 0, S_IDLE, 0, O_IDLE);
        for (int i = 0; i < 16; i++) begin
            step($sformatf("ext10_%0d", i), 0, 0, S_IOW, (i > 10),
                 {(i >= 13), 1'b1, 1'b0, (i != 0)});
        end
        step("ext10_rel",  0, 0, S_IDLE, 1, O_ACT);
        step("ext10_idle", 0, 0, S_IDLE, 1, O_IDLE);

        // Slot stuck low: forced completion after 64 EXT clocks with a
        // single-clock timeout_error, then the held strobe is not restarted.
        for (int i = 0; i < 3; i++) step("tmo_pre", 0, 0, S_IDLE, 0, O_IDLE);
        for (int i = 0; i < 69; i++) begin
            step($sformatf("tmo_%0d", i), 0, 0, S_IOW, 0,
                 {(i >= 65), 1'b1, (i == 65), (i != 0)});
        end
        step("tmo_rel",    0, 0, S_IDLE, 1, O_ACT);
        step("tmo_idle",   0, 0, S_IDLE, 1, O_IDLE);
        step("tmo_next_k", 0, 0, S_IOW,  1, O_PR0);
        step("tmo_next_1", 0, 0, S_IOW,  1, O_ACT);
        step("tmo_next_r", 0, 0, S_IDLE, 1, O_ACT);
        step("tmo_next_i", 0, 0, S_IDLE, 1, O_IDLE);

        // Reset asserted between edges while in EXT.
        for (int i = 0; i < 3; i++) step("rst_pre", 0, 0, S_IDLE, 0, O_IDLE);
        step("rst_k",  0, 0, S_IOW, 0, O_PR0);
        step("rst_k1", 0, 0, S_IOW, 0, O_PR0_ACT);
        step("rst_k2", 0, 0, S_IOW, 0, O_PR0_ACT);
        step("rst_k3", 0, 0, S_IOW, 0, O_PR0_ACT);
        #2;
        reset = 1'b1;
        #1;
        push_exp("rst_async", 0, O_IDLE);
        sample();
        drive_bus(1'b0, 1'b0, S_IDLE, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        step("rst_after", 0, 0, S_IDLE, 1, O_IDLE);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left unchecked", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
